// File: rtl/screensaver_pkg.sv
// ---------------------------------------------------------------------------
// screensaver_pkg : shared types and helpers for the bouncing sprite.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package screensaver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2,
    COMMIT = 2'd3
  } state_e;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_e;

  localparam int NUM_COLORS = 6;
  localparam int COORD_W    = 10;

  // Largest top-left coordinate that keeps the sprite fully on screen.
  function automatic int axis_limit(input int visible, input int size);
    return visible - size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bounce_axis.sv
// ---------------------------------------------------------------------------
// bounce_axis : one-axis position step with edge clamp and direction flip.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bounce_axis
  import screensaver_pkg::*;
#(
  parameter int W = COORD_W
) (
  input  logic [W-1:0] p,
  input  logic [3:0]   step,
  input  dir_e         dir,
  input  logic [W-1:0] limit,
  output logic [W-1:0] n,
  output dir_e         dir_n,
  output logic         hit
);

  // One spare bit so p+step cannot wrap before it is compared with the limit.
  logic [W:0] p_ext;
  logic [W:0] step_ext;
  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    p_ext    = {1'b0, p};
    step_ext = (W+1)'(step);
    sum      = p_ext + step_ext;
    diff     = p_ext - step_ext;
    n        = p;
    dir_n    = dir;
    hit      = 1'b0;
    if (dir == DIR_POS) begin
      if (sum >= {1'b0, limit}) begin
        n     = limit;
        dir_n = DIR_NEG;
        hit   = 1'b1;
      end else begin
        n = sum[W-1:0];
      end
    end else begin
      if (p_ext <= step_ext) begin
        n     = '0;
        dir_n = DIR_POS;
        hit   = 1'b1;
      end else begin
        n = diff[W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_motion_ctrl : per-frame bouncing sprite position and colour update.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sprite_motion_ctrl
  import screensaver_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int SPRITE_W  = 64,
  parameter int SPRITE_H  = 32,
  parameter int START_X   = 100,
  parameter int START_Y   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [3:0] step_x,
  input  logic [3:0] step_y,
  output logic [9:0] sprite_x,
  output logic [8:0] sprite_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic [2:0] color_idx,
  output logic       bounce,
  output logic       corner_hit,
  output logic       overrun,
  output logic       busy
);

  localparam logic [9:0] LIM_X = 10'(axis_limit(H_VISIBLE, SPRITE_W));
  localparam logic [9:0] LIM_Y = 10'(axis_limit(V_VISIBLE, SPRITE_H));

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d, wx_q, wx_d;
  logic [8:0] y_q, y_d, wy_q, wy_d;
  dir_e       dx_q, dx_d, dy_q, dy_d, wdx_q, wdx_d, wdy_q, wdy_d;
  logic       hx_q, hx_d, hy_q, hy_d;
  logic [3:0] stx_q, stx_d, sty_q, sty_d;
  logic [2:0] color_q, color_d;
  logic       bounce_q, bounce_d, corner_q, corner_d, overrun_q, overrun_d;

  logic [9:0] ax_p, ax_limit, ax_n;
  logic [3:0] ax_step;
  dir_e       ax_dir, ax_dir_n;
  logic       ax_hit;

  // The single axis unit serves x during MOVE_X and y otherwise.
  always_comb begin
    ax_p     = (state_q == MOVE_X) ? x_q   : {1'b0, y_q};
    ax_step  = (state_q == MOVE_X) ? stx_q : sty_q;
    ax_dir   = (state_q == MOVE_X) ? dx_q  : dy_q;
    ax_limit = (state_q == MOVE_X) ? LIM_X : LIM_Y;
  end

  bounce_axis #(.W(10)) u_axis (
    .p     (ax_p),
    .step  (ax_step),
    .dir   (ax_dir),
    .limit (ax_limit),
    .n     (ax_n),
    .dir_n (ax_dir_n),
    .hit   (ax_hit)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    wdx_d     = wdx_q;
    wdy_d     = wdy_q;
    hx_d      = hx_q;
    hy_d      = hy_q;
    stx_d     = stx_q;
    sty_d     = sty_q;
    color_d   = color_q;
    bounce_d  = 1'b0;
    corner_d  = 1'b0;
    overrun_d = frame_tick && enable && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (frame_tick && enable) begin
          stx_d   = step_x;
          sty_d   = step_y;
          state_d = MOVE_X;
        end
      end
      MOVE_X: begin
        wx_d    = ax_n;
        wdx_d   = ax_dir_n;
        hx_d    = ax_hit;
        state_d = MOVE_Y;
      end
      MOVE_Y: begin
        wy_d    = ax_n[8:0];
        wdy_d   = ax_dir_n;
        hy_d    = ax_hit;
        state_d = COMMIT;
      end
      COMMIT: begin
        x_d  = wx_q;
        y_d  = wy_q;
        dx_d = wdx_q;
        dy_d = wdy_q;
        if (hx_q || hy_q) begin
          bounce_d = 1'b1;
          corner_d = hx_q && hy_q;
          color_d  = (color_q == 3'(NUM_COLORS - 1)) ? 3'd0 : color_q + 3'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      x_q       <= 10'(START_X);
      y_q       <= 9'(START_Y);
      dx_q      <= DIR_POS;
      dy_q      <= DIR_POS;
      wx_q      <= '0;
      wy_q      <= '0;
      wdx_q     <= DIR_NEG;
      wdy_q     <= DIR_NEG;
      hx_q      <= 1'b0;
      hy_q      <= 1'b0;
      stx_q     <= '0;
      sty_q     <= '0;
      color_q   <= '0;
      bounce_q  <= 1'b0;
      corner_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      wdx_q     <= wdx_d;
      wdy_q     <= wdy_d;
      hx_q      <= hx_d;
      hy_q      <= hy_d;
      stx_q     <= stx_d;
      sty_q     <= sty_d;
      color_q   <= color_d;
      bounce_q  <= bounce_d;
      corner_q  <= corner_d;
      overrun_q <= overrun_d;
    end
  end

  assign sprite_x   = x_q;
  assign sprite_y   = y_q;
  assign dir_x      = dx_q;
  assign dir_y      = dy_q;
  assign color_idx  = color_q;
  assign bounce     = bounce_q;
  assign corner_hit = corner_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sprite_motion_ctrl : directed checks of sprite_motion_ctrl variants.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sprite_motion_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       tick [4];
  logic [3:0] step_x;
  logic [3:0] step_y;

  logic [9:0] sx [4];
  logic [8:0] sy [4];
  logic       dx [4];
  logic       dy [4];
  logic [2:0] col [4];
  logic       bnc [4];
  logic       crn [4];
  logic       ovr [4];
  logic       bsy [4];

  int n_checks = 0;
  int n_fail   = 0;

  // 0: defaults, 1: near right edge, 2: near corner, 3: 4-pixel-wide playfield
  sprite_motion_ctrl u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(tick[0]),
    .step_x(step_x), .step_y(step_y),
    .sprite_x(sx[0]), .sprite_y(sy[0]), .dir_x(dx[0]), .dir_y(dy[0]),
    .color_idx(col[0]), .bounce(bnc[0]), .corner_hit(crn[0]),
    .overrun(ovr[0]), .busy(bsy[0])
  );

  sprite_motion_ctrl #(.START_X(570), .START_Y(50)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(tick[1]),
    .step_x(step_x), .step_y(step_y),
    .sprite_x(sx[1]), .sprite_y(sy[1]), .dir_x(dx[1]), .dir_y(dy[1]),
    .color_idx(col[1]), .bounce(bnc[1]), .corner_hit(crn[1]),
    .overrun(ovr[1]), .busy(bsy[1])
  );

  sprite_motion_ctrl #(.START_X(572), .START_Y(446)) u_dut_c (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(tick[2]),
    .step_x(step_x), .step_y(step_y),
    .sprite_x(sx[2]), .sprite_y(sy[2]), .dir_x(dx[2]), .dir_y(dy[2]),
    .color_idx(col[2]), .bounce(bnc[2]), .corner_hit(crn[2]),
    .overrun(ovr[2]), .busy(bsy[2])
  );

  sprite_motion_ctrl #(.H_VISIBLE(68), .SPRITE_W(64), .START_X(0)) u_dut_d (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(tick[3]),
    .step_x(step_x), .step_y(step_y),
    .sprite_x(sx[3]), .sprite_y(sy[3]), .dir_x(dx[3]), .dir_y(dy[3]),
    .color_idx(col[3]), .bounce(bnc[3]), .corner_hit(crn[3]),
    .overrun(ovr[3]), .busy(bsy[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame_tick for instance `which`; returns just after the commit edge.
  task automatic frame(input int which);
    @(negedge clk);
    tick[which] = 1'b1;
    @(negedge clk);
    tick[which] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int exp_col [6] = '{1, 2, 3, 4, 5, 0};

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    step_x  = '0;
    step_y  = '0;
    for (int i = 0; i < 4; i++) tick[i] = 1'b0;

    #2 rst = 1'b0;
    #1;
    check("rst_x", sx[0], 100);
    check("rst_y", sy[0], 50);
    check("rst_dx", dx[0], 1);
    check("rst_dy", dy[0], 1);
    check("rst_col", col[0], 0);
    check("rst_busy", bsy[0], 0);
    check("rst_bounce", bnc[0], 0);
    check("rst_overrun", ovr[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Plain interior move
    step_x = 4'd5;
    step_y = 4'd3;
    frame(0);
    check("move_x", sx[0], 105);
    check("move_y", sy[0], 53);
    check("move_busy", bsy[0], 0);
    check("move_bounce", bnc[0], 0);
    check("move_dx", dx[0], 1);

    // Back-to-back ticks: second one dropped with overrun
    @(negedge clk);
    step_x = 4'd1;
    step_y = 4'd1;
    tick[0] = 1'b1;
    @(negedge clk);
    check("ovr_busy0", bsy[0], 1);
    check("ovr_early", ovr[0], 0);
    @(negedge clk);
    tick[0] = 1'b0;
    check("ovr_pulse", ovr[0], 1);
    check("ovr_busy1", bsy[0], 1);
    check("ovr_x_hold", sx[0], 105);
    @(negedge clk);
    check("ovr_clear", ovr[0], 0);
    check("ovr_busy2", bsy[0], 1);
    check("ovr_x_hold2", sx[0], 105);
    @(negedge clk);
    check("ovr_busy3", bsy[0], 0);
    check("ovr_x", sx[0], 106);
    check("ovr_y", sy[0], 54);
    repeat (4) @(negedge clk);
    check("ovr_single_x", sx[0], 106);
    check("ovr_single_y", sy[0], 54);

    // Disabled tick is ignored with no overrun
    @(negedge clk);
    enable  = 1'b0;
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    check("dis_busy", bsy[0], 0);
    check("dis_ovr", ovr[0], 0);
    @(negedge clk);
    check("dis_x", sx[0], 106);

    // Dropping enable mid-update lets it finish
    enable = 1'b1;
    step_x = 4'd2;
    step_y = 4'd2;
    @(negedge clk);
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    check("dis_mid_x", sx[0], 108);
    check("dis_mid_y", sy[0], 56);
    enable = 1'b1;

    // Reset during MOVE_Y discards the update
    step_x = 4'd7;
    step_y = 4'd7;
    @(negedge clk);
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_x", sx[0], 100);
    check("mid_rst_y", sy[0], 50);
    check("mid_rst_busy", bsy[0], 0);
    check("mid_rst_bounce", bnc[0], 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_nobounce", bnc[0], 0);
    check("mid_rst_hold_x", sx[0], 100);
    frame(0);
    check("resume_x", sx[0], 107);
    check("resume_y", sy[0], 57);

    // Right-edge hit from x = 570
    step_x = 4'd8;
    step_y = 4'd0;
    @(negedge clk);
    tick[1] = 1'b1;
    @(negedge clk);
    tick[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("edge_pre_bounce", bnc[1], 0);
    check("edge_pre_x", sx[1], 570);
    @(negedge clk);
    check("edge_x", sx[1], 576);
    check("edge_dx", dx[1], 0);
    check("edge_col", col[1], 1);
    check("edge_bounce", bnc[1], 1);
    check("edge_corner", crn[1], 0);
    check("edge_y", sy[1], 50);
    check("edge_dy", dy[1], 1);
    @(negedge clk);
    check("edge_bounce_end", bnc[1], 0);

    // Corner hit from 572/446
    step_x = 4'd4;
    step_y = 4'd2;
    frame(2);
    check("corner_x", sx[2], 576);
    check("corner_y", sy[2], 448);
    check("corner_dx", dx[2], 0);
    check("corner_dy", dy[2], 0);
    check("corner_hit", crn[2], 1);
    check("corner_bounce", bnc[2], 1);
    check("corner_col", col[2], 1);
    @(negedge clk);
    check("corner_end", crn[2], 0);

    // Narrow playfield bounces every frame: colour wraps 1..5,0
    step_x = 4'd4;
    step_y = 4'd0;
    for (int k = 0; k < 6; k++) begin
      frame(3);
      check("wrap_col", col[3], exp_col[k]);
      check("wrap_x", sx[3], (k % 2 == 0) ? 4 : 0);
      check("wrap_bounce", bnc[3], 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_VISIBLE, 640, visible width in pixels
- V_VISIBLE, 480, visible height in lines
- SPRITE_W, 64, sprite width
- SPRITE_H, 32, sprite height
- START_X, 100, reset x
- START_Y, 50, reset y
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, pixel clock
- rst, in, 1, asynchronous active-low reset
- enable, in, 1, motion enable
- frame_tick, in, 1, one-cycle pulse, once per frame, at start of vertical blanking
- step_x, in, 4, pixels per frame in x
- step_y, in, 4, lines per frame in y
- sprite_x, out, 10, top-left x
- sprite_y, out, 9, top-left y
- dir_x, out, 1, 1 = moving right
- dir_y, out, 1, 1 = moving down
- color_idx, out, 3, palette index 0..5
- bounce, out, 1, one-cycle pulse on any edge hit
- corner_hit, out, 1, one-cycle pulse on simultaneous x and y hit
- overrun, out, 1, one-cycle pulse when frame_tick is dropped
- busy, out, 1, high while state != IDLE

Function
REQ-003 The FSM SHALL have four states: IDLE, MOVE_X, MOVE_Y, COMMIT.
REQ-004 In IDLE, when frame_tick = 1 and enable = 1, the FSM SHALL capture step_x/step_y and go to MOVE_X; otherwise it SHALL stay in IDLE.
REQ-005 MOVE_X SHALL compute the working x and dir_x and go to MOVE_Y; MOVE_Y SHALL compute the working y and dir_y and go to COMMIT; COMMIT SHALL go to IDLE unconditionally.
REQ-006 X and Y SHALL be computed by one shared axis unit, time-multiplexed by state; there SHALL be no duplicated adder/compare.
REQ-007 Axis rule, with limit L = H_VISIBLE-SPRITE_W (576) or V_VISIBLE-SPRITE_H (448):
- forward: n = p+step; if n >= L, then n = L, dir flips, hit = 1
- backward: if p <= step, then n = 0, dir flips, hit = 1; else n = p-step
REQ-008 Step 0 SHALL produce no motion and no hit, except when p already sits at the limit in the current direction (p = L forward, or p = 0 backward): then the rule applies and a hit is produced.
REQ-009 Axis arithmetic SHALL be 1 bit wider than the coordinate, so no overflow occurs before the compare.
REQ-010 The sprite_x/sprite_y/dir_x/dir_y outputs SHALL update only at the COMMIT edge, so all four change on the same cycle.
REQ-011 Latency: frame_tick sampled at edge N SHALL give updated outputs after edge N+3.
REQ-012 At COMMIT:
- any hit: bounce = 1 for one cycle, and color_idx increments modulo 6 (5 -> 0)
- both hits: corner_hit = 1 as well, and color_idx increments once only
REQ-013 A frame_tick while busy = 1 SHALL be dropped, overrun SHALL pulse the next cycle, and the update in progress SHALL be unaffected.
REQ-014 With enable = 0, frame_tick SHALL be ignored with no overrun; an update already started SHALL complete.
REQ-015 Pulse outputs SHALL be registered and never asserted together with a reset.

Reset
REQ-016 With rst = 0, asynchronously:
- sprite_x = START_X, sprite_y = START_Y
- dir_x = 1, dir_y = 1
- color_idx = 0
- bounce = corner_hit = overrun = 0
- busy = 0, state = IDLE
- working registers cleared
REQ-017 Reset mid-update SHALL discard the pending update with no pulse; operation SHALL resume on the first frame_tick after rst deasserts.

Structure
REQ-018 A shared package screensaver_pkg SHALL hold:
- state enum
- NUM_COLORS = 6
- direction typedef
- the axis limit computation function
REQ-019 One sub-module, bounce_axis (combinational: p, step, dir, limit -> n, new dir, hit), SHALL be instantiated once.

Verification
REQ-020 Reset: assert rst = 0 mid-run -> sprite_x = 100, sprite_y = 50, dir = 1/1, color_idx = 0, busy = 0, the same cycle.
REQ-021 Right edge: START_X = 570, step_x = 8, step_y = 0, one frame_tick -> sprite_x = 576, dir_x = 0, color_idx = 1, bounce for 1 cycle at N+3.
REQ-022 Corner: START_X = 572, START_Y = 446, step 4/2 -> 576/448, dir 0/0, corner_hit = 1, bounce = 1, color_idx = 1.
REQ-023 Color wrap: force six successive bounces -> color_idx sequence 1,2,3,4,5,0.
REQ-024 Overrun: frame_tick at N and N+1 -> overrun at N+2, exactly one position update, busy high for 3 cycles.
REQ-025 Mid-update reset: rst = 0 during MOVE_Y -> reset values, no bounce; the next frame_tick updates normally from START_X/START_Y.
